// File: rtl/multicycle_control_unit.sv
// Multi-cycle fetch/decode sequencer for the tiny RV32I core: fetches over a
// req/valid handshake, decodes OP/OP-IMM/LUI/BEQ/BNE and steers the ALU.
module multicycle_control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_valid,
  input  logic [31:0] instr_data,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        reg_we,
  output logic        selopr2,
  output logic [3:0]  aluoper,
  output logic [31:0] imm_out,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, SETTLE, WB, HALT} state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t state, state_nxt;

  logic       is_branch, is_bne, illegal;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [3:0] base_op;

  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_selopr2, dec_branch, dec_bne, dec_illegal;
  logic [3:0]  dec_aluoper;
  logic [31:0] dec_imm;

  logic        accept, taken, misaligned;
  logic [31:0] target;

  // Writeback data travels from the ALU straight to the register file.
  logic unused_alu_result;
  assign unused_alu_result = ^alu_result;

  assign opcode = instr_data[6:0];
  assign funct3 = instr_data[14:12];
  assign funct7 = instr_data[31:25];

  // Decode the word on the fetch bus; the result is captured only on accept.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    dec_rs1     = instr_data[19:15];
    dec_rs2     = instr_data[24:20];
    dec_rd      = instr_data[11:7];
    dec_selopr2 = 1'b0;
    dec_aluoper = ALU_ADD;
    dec_imm     = '0;
    dec_branch  = 1'b0;
    dec_bne     = 1'b0;
    dec_illegal = 1'b1;

    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase

    case (opcode)
      OPC_OP: begin
        dec_aluoper = base_op;
        if (funct7 == F7_ZERO) begin
          dec_illegal = 1'b0;
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_illegal = 1'b0;
          dec_aluoper = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        dec_selopr2 = 1'b1;
        dec_aluoper = base_op;
        dec_rs2     = '0;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_imm = {27'b0, instr_data[24:20]};
          if (funct7 == F7_ZERO) begin
            dec_illegal = 1'b0;
          end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
            dec_illegal = 1'b0;
            dec_aluoper = ALU_SRA;
          end
        end else begin
          dec_imm     = {{20{instr_data[31]}}, instr_data[31:20]};
          dec_illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_selopr2 = 1'b1;
        dec_imm     = {instr_data[31:12], 12'b0};
        dec_illegal = 1'b0;
      end
      OPC_BRANCH: begin
        dec_rd      = '0;
        dec_aluoper = ALU_SUB;
        dec_branch  = 1'b1;
        dec_bne     = funct3[0];
        dec_imm     = {{19{instr_data[31]}}, instr_data[31], instr_data[7],
                       instr_data[30:25], instr_data[11:8], 1'b0};
        dec_illegal = (funct3[2:1] != 2'b00);
      end
      default: ;
    endcase
  end

  assign accept     = (state == FETCH) && instr_req && instr_valid;
  assign taken      = is_bne ? !alu_zero : alu_zero;
  assign target     = pc + imm_out;
  assign misaligned = is_branch && taken && target[1];

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (accept) state_nxt = DECODE;
      DECODE:  state_nxt = illegal ? HALT : EXEC;
      EXEC:    state_nxt = SETTLE;
      SETTLE:  state_nxt = WB;
      WB:      state_nxt = misaligned ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  assign instr_addr = pc;
  assign reg_we     = (state == WB) && !is_branch && (rd_addr != 5'd0);
  assign retire     = (state == WB) && !misaligned;
  assign halted     = (state == HALT);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (reset) begin
      state     <= FETCH;
      instr_req <= 1'b0;
      pc        <= RESET_PC;
      instret   <= '0;
      rs1_addr  <= '0;
      rs2_addr  <= '0;
      rd_addr   <= '0;
      selopr2   <= 1'b0;
      aluoper   <= ALU_ADD;
      imm_out   <= '0;
      is_branch <= 1'b0;
      is_bne    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Registered so the request is low for the first cycle out of reset.
      instr_req <= (state_nxt == FETCH);
      if (accept) begin
        rs1_addr  <= dec_rs1;
        rs2_addr  <= dec_rs2;
        rd_addr   <= dec_rd;
        selopr2   <= dec_selopr2;
        aluoper   <= dec_aluoper;
        imm_out   <= dec_imm;
        is_branch <= dec_branch;
        is_bne    <= dec_bne;
        illegal   <= dec_illegal;
      end
      if (retire) begin
        pc      <= (is_branch && taken) ? target : pc + 32'd4;
        instret <= instret + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: a tiny assembler produces each instruction together with
// its expected decode, and an architectural pc/instret model tracks retirement.
module tb_multicycle_control_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        reg_we, selopr2;
  logic [3:0]  aluoper;
  logic [31:0] imm_out;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        halted;

  multicycle_control_unit #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .reg_we(reg_we), .selopr2(selopr2), .aluoper(aluoper), .imm_out(imm_out),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .pc(pc), .retire(retire), .instret(instret), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          legal;
    bit          br;
    bit          bne;
    logic        sel;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    bit          chk_imm;
    bit          chk_rs2;
  } exp_t;

  // ALU code -> funct3 / uses the alternate funct7 (add sub xor or and sll srl sra slt sltu)
  int f3_of  [10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
  int alt_of [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
  int i_codes [6] = '{0, 2, 3, 4, 8, 9};
  int bad_f3  [6] = '{1, 2, 3, 4, 6, 7};
  int bad_opc [6] = '{'h03, 'h23, 'h6f, 'h67, 'h17, 'h00};

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instret;
  bit          m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(bit legal, bit br, bit bne, logic sel, logic [3:0] op,
                              logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, bit chk_imm, bit chk_rs2);
    exp_t e;
    e.legal = legal; e.br = br; e.bne = bne; e.sel = sel; e.op = op; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.chk_imm = chk_imm; e.chk_rs2 = chk_rs2;
    return e;
  endfunction

  function automatic logic [31:0] asm_r(input int code, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        output exp_t e);
    logic [6:0] f7;
    f7 = (alt_of[code] != 0) ? 7'h20 : 7'h00;
    e = mk(1, 0, 0, 1'b0, 4'(code), 32'h0, rs1, rs2, rd, 0, 1);
    return {f7, rs2, rs1, 3'(f3_of[code]), rd, 7'h33};
  endfunction

  function automatic logic [31:0] asm_i(input int code, input logic [4:0] rd,
                                        input logic [4:0] rs1, input int imm, output exp_t e);
    logic [11:0] i12;
    i12 = 12'(imm);
    e = mk(1, 0, 0, 1'b1, 4'(code), 32'(imm), rs1, 5'd0, rd, 1, 0);
    return {i12, rs1, 3'(f3_of[code]), rd, 7'h13};
  endfunction

  function automatic logic [31:0] asm_sh(input int code, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] shamt,
                                         output exp_t e);
    logic [6:0] f7;
    f7 = (alt_of[code] != 0) ? 7'h20 : 7'h00;
    e = mk(1, 0, 0, 1'b1, 4'(code), {27'b0, shamt}, rs1, 5'd0, rd, 1, 0);
    return {f7, shamt, rs1, 3'(f3_of[code]), rd, 7'h13};
  endfunction

  function automatic logic [31:0] asm_lui(input logic [4:0] rd, input logic [19:0] up,
                                          output exp_t e);
    e = mk(1, 0, 0, 1'b1, 4'd0, {up, 12'b0}, 5'd0, 5'd0, rd, 1, 0);
    return {up, rd, 7'h37};
  endfunction

  function automatic logic [31:0] asm_br(input bit bne, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input int off, output exp_t e);
    logic [12:0] o;
    o = 13'(off);
    e = mk(1, 1, bne, 1'b0, 4'd1, 32'(off), rs1, rs2, 5'd0, 1, 1);
    return {o[12], o[10:5], rs2, rs1, 2'b00, bne, o[4:1], o[11], 7'h63};
  endfunction

  function automatic logic [31:0] gen_illegal(output exp_t e);
    logic [31:0] ins;
    e = mk(0, 0, 0, 1'b0, 4'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0);
    case ($urandom_range(0, 4))
      0: ins = {7'h20, 5'($urandom), 5'($urandom), 3'(bad_f3[$urandom_range(0, 5)]), 5'($urandom), 7'h33};
      1: ins = {7'h01, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
      2: ins = ($urandom_range(0, 1) == 0) ?
               {7'h20, 5'($urandom), 5'($urandom), 3'b001, 5'($urandom), 7'h13} :
               {7'h10, 5'($urandom), 5'($urandom), 3'b101, 5'($urandom), 7'h13};
      3: ins = {7'($urandom), 5'($urandom), 5'($urandom), 3'($urandom_range(2, 7)), 5'($urandom), 7'h63};
      default: ins = {25'($urandom), 7'(bad_opc[$urandom_range(0, 5)])};
    endcase
    return ins;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    alu_zero = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_pc", pc, RST_PC);
    check("rst_instret", instret, 32'h0);
    check("rst_halted", halted, 0);
    check("rst_req", instr_req, 0);
    check("rst_we", reg_we, 0);
    check("rst_retire", retire, 0);
    check("rst_sel", selopr2, 0);
    check("rst_op", aluoper, 0);
    check("rst_imm", imm_out, 0);
    check("rst_regs", {rs1_addr, rs2_addr, rd_addr}, 0);
    m_pc = RST_PC;
    m_instret = 0;
    m_halted = 0;
  endtask

  task automatic wait_req();
    int guard = 0;
    while (!instr_req && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    check("req_ready", instr_req, 1);
  endtask

  // Drive one instruction through the sequencer and check each phase against e.
  task automatic run_instr(input logic [31:0] ins, input exp_t e, input int waits, input bit zero);
    bit          tk, mis;
    logic [31:0] tgt;
    wait_req();
    for (int w = 0; w < waits; w++) begin
      check("req_hold", instr_req, 1);
      check("fetch_addr", instr_addr, m_pc);
      instr_valid = 1'b0;
      instr_data = $urandom;
      @(negedge clock);
    end
    check("req_hold", instr_req, 1);
    check("fetch_addr", instr_addr, m_pc);
    instr_valid = 1'b1;
    instr_data = ins;
    @(negedge clock);
    // DECODE
    instr_valid = 1'($urandom);
    instr_data = $urandom;
    alu_zero = 1'($urandom);
    check("dec_req", instr_req, 0);
    if (!e.legal) begin
      @(negedge clock);
      instr_valid = 1'b0;
      check("ill_halted", halted, 1);
      check("ill_req", instr_req, 0);
      check("ill_pc", pc, m_pc);
      check("ill_retire", retire, 0);
      m_halted = 1;
      return;
    end
    check("dec_halted", halted, 0);
    check("dec_sel", selopr2, e.sel);
    check("dec_op", aluoper, e.op);
    check("dec_rs1", rs1_addr, e.rs1);
    if (e.chk_imm) check("dec_imm", imm_out, e.imm);
    if (e.chk_rs2) check("dec_rs2", rs2_addr, e.rs2);
    if (!e.br) check("dec_rd", rd_addr, e.rd);
    @(negedge clock);
    // EXEC
    check("exec_we", reg_we, 0);
    check("exec_retire", retire, 0);
    @(negedge clock);
    // SETTLE
    check("settle_retire", retire, 0);
    alu_zero = zero;
    @(negedge clock);
    // WB
    tk  = e.br && (e.bne ? !zero : zero);
    tgt = m_pc + e.imm;
    mis = tk && tgt[1];
    check("wb_we", reg_we, (!e.br && e.rd != 0) ? 1 : 0);
    check("wb_retire", retire, mis ? 0 : 1);
    check("wb_op_hold", aluoper, e.op);
    if (e.chk_imm) check("wb_imm_hold", imm_out, e.imm);
    instr_valid = 1'b0;
    @(negedge clock);
    if (mis) begin
      check("mis_halted", halted, 1);
      check("mis_pc", pc, m_pc);
      check("mis_req", instr_req, 0);
      m_halted = 1;
    end else begin
      m_pc = tk ? tgt : m_pc + 4;
      m_instret = m_instret + 1;
      check("next_halted", halted, 0);
      check("next_req", instr_req, 1);
    end
    check("pc", pc, m_pc);
    check("instret", instret, m_instret);
  endtask

  task automatic reset_in_exec();
    exp_t        e;
    logic [31:0] ins;
    ins = asm_i(0, 5'd7, 5'd0, 9, e);
    wait_req();
    instr_valid = 1'b1;
    instr_data = ins;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    // EXEC: reset lands on the closing edge of this cycle
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_pc = RST_PC;
    m_instret = 0;
    m_halted = 0;
    check("rexec_req", instr_req, 0);
    check("rexec_pc", pc, RST_PC);
    check("rexec_instret", instret, 0);
    for (int i = 0; i < 3; i++) begin
      check("rexec_we", reg_we, 0);
      check("rexec_retire", retire, 0);
      @(negedge clock);
    end
    check("rexec_refetch", instr_req, 1);
    check("rexec_addr", instr_addr, RST_PC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [31:0] ins;
    exp_t        e_addi, e_beq;
    int          k;

    reset = 1'b1;
    instr_valid = 1'b0;
    instr_data = '0;
    alu_zero = 1'b0;
    alu_result = '0;

    e_addi = mk(1, 0, 0, 1'b1, 4'd0, 32'd5, 5'd0, 5'd0, 5'd1, 1, 0);
    e_beq  = mk(1, 1, 0, 1'b0, 4'd1, 32'd8, 5'd1, 5'd1, 5'd0, 1, 1);

    do_reset();
    run_instr(32'h00500093, e_addi, 3, 0);
    run_instr(32'h402081B3, mk(1, 0, 0, 1'b0, 4'd1, 32'h0, 5'd1, 5'd2, 5'd3, 0, 1), 0, 0);
    run_instr(32'h4030D213, mk(1, 0, 0, 1'b1, 4'd7, 32'd3, 5'd1, 5'd0, 5'd4, 1, 0), 1, 0);
    run_instr(32'h123452B7, mk(1, 0, 0, 1'b1, 4'd0, 32'h1234_5000, 5'd0, 5'd0, 5'd5, 1, 0), 0, 1);

    // beq +8 from pc = base+8, taken then not taken
    do_reset();
    run_instr(32'h00500093, e_addi, 0, 0);
    run_instr(32'h00500093, e_addi, 0, 0);
    run_instr(32'h00108463, e_beq, 0, 1);
    check("beq_taken_pc", pc, RST_PC + 16);
    do_reset();
    run_instr(32'h00500093, e_addi, 0, 0);
    run_instr(32'h00500093, e_addi, 0, 0);
    run_instr(32'h00108463, e_beq, 2, 0);
    check("beq_fall_pc", pc, RST_PC + 12);

    // all-zero word halts; halt must ignore the fetch bus until reset
    run_instr(32'h0000_0000, mk(0, 0, 0, 1'b0, 4'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0), 0, 0);
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1;
      instr_data = 32'h00500093;
      @(negedge clock);
      check("halt_sticky", halted, 1);
      check("halt_req", instr_req, 0);
      check("halt_pc", pc, m_pc);
      check("halt_retire", retire, 0);
    end
    do_reset();
    @(negedge clock);
    check("post_halt_req", instr_req, 1);
    check("post_halt_addr", instr_addr, RST_PC);

    reset_in_exec();
    run_instr(32'h00500093, e_addi, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      if (m_halted) do_reset();
      k = $urandom_range(0, 11);
      if (k <= 2) begin
        ins = asm_r($urandom_range(0, 9), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    5'($urandom), 5'($urandom), e);
      end else if (k <= 4) begin
        ins = asm_i(i_codes[$urandom_range(0, 5)], 5'($urandom), 5'($urandom),
                    int'($urandom_range(0, 4095)) - 2048, e);
      end else if (k == 5) begin
        ins = asm_sh($urandom_range(5, 7), 5'($urandom), 5'($urandom), 5'($urandom), e);
      end else if (k == 6) begin
        ins = asm_lui(5'($urandom), 20'($urandom), e);
      end else if (k <= 9) begin
        ins = asm_br(1'($urandom), 5'($urandom), 5'($urandom),
                     4 * (int'($urandom_range(0, 32)) - 16), e);
      end else if (k == 10) begin
        ins = gen_illegal(e);
      end else begin
        ins = asm_br(1'($urandom), 5'($urandom), 5'($urandom),
                     4 * (int'($urandom_range(0, 16)) - 8) + 2, e);
      end
      run_instr(ins, e, $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle fetch/decode sequencer sitting directly upstream of the ALU in the tiny RISC-V CPU. It fetches a 32-bit instruction over a request/valid handshake and decodes RV32I OP, OP-IMM, LUI, BEQ and BNE. It drives the ALU operand-select, operation code and immediate, plus the register-file addresses and write strobe. It consumes the ALU result and zero flag to decide writeback and branches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
instr_req  output  1  fetch request; held until instr_valid
instr_addr  output  32  fetch address (= pc)
instr_valid  input  1  instr_data valid this cycle
instr_data  input  32  fetched instruction
rs1_addr  output  5  register-file read port 1 address
rs2_addr  output  5  register-file read port 2 address
rd_addr  output  5  register-file write address
reg_we  output  1  register-file write strobe, one cycle
selopr2  output  1  ALU operand 2 select: 0 = rs2 data, 1 = immediate
aluoper  output  4  ALU operation code
imm_out  output  32  decoded immediate to ALU
alu_result  input  32  registered ALU result
alu_zero  input  1  ALU zero flag
pc  output  32  current program counter
retire  output  1  one-cycle pulse per completed instruction
instret  output  32  retired-instruction counter
halted  output  1  sticky; set on illegal instruction

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, instr_req=0, reg_we=0, retire=0, halted=0, instret=0, selopr2=0, aluoper=0, imm_out=0, all register addresses 0.
- Reset at any state, including mid-fetch, aborts the operation and returns to FETCH. instr_req is low in the cycle after reset.
- States: FETCH -> DECODE -> EXEC -> SETTLE -> WB -> FETCH. HALT is terminal until reset.
- FETCH: instr_req=1, instr_addr=pc. On instr_valid, latch instr_data and go to DECODE. Wait indefinitely otherwise. instr_valid is ignored in every other state.
- DECODE (1 cycle): drive rs1_addr/rs2_addr/rd_addr, selopr2, aluoper and imm_out from the latched instruction. These outputs hold stable through WB. An unsupported opcode/funct combination goes to HALT.
- EXEC (1 cycle): the ALU samples its operands at the end of this cycle. alu_result is valid in SETTLE. alu_zero is valid in WB.
- ALU codes: 0000 add, 0001 sub (R-type only; selopr2=0), 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu.
- OP (0110011): selopr2=0. funct7=0100000 is valid only with funct3 000 (sub) or 101 (sra).
- OP-IMM (0010011): selopr2=1, imm_out = sign-extended I-imm.
  - slli/srli/srai: imm_out = zero-extended shamt instr[24:20].
  - srai requires funct7=0100000; slli/srli require funct7=0000000.
- LUI (0110111): rs1_addr=0, aluoper=0000, selopr2=1, imm_out = {instr[31:12], 12'b0}.
- BEQ/BNE (1100011, funct3 000/001): aluoper=0001, selopr2=0, imm_out = sign-extended B-imm. No register write.
- WB (1 cycle):
  - ALU instructions: reg_we=1 if rd_addr != 0, else 0. pc <= pc+4.
  - Branches: taken = alu_zero for BEQ, !alu_zero for BNE. Taken: pc <= pc+imm_out; not taken: pc <= pc+4.
  - A taken target with bit1 set goes to HALT without updating pc and without retire.
- retire pulses in WB. instret increments by 1 on each retire, wrapping 32'hFFFF_FFFF -> 0.
- HALT: halted=1, instr_req=0, reg_we=0, pc frozen, no further retire.
- Latency: 5 cycles per instruction plus fetch wait cycles.

Test Plan:
- Reset, then instr_data=0x00500093 (addi x1,x0,5) with instr_valid after 3 wait cycles -> instr_req held for 4 cycles; selopr2=1, aluoper=0000, imm_out=5, rd_addr=1; reg_we and retire pulse in WB; pc=4, instret=1.
- 0x402081B3 (sub x3,x1,x2) -> selopr2=0, aluoper=0001, rs1_addr=1, rs2_addr=2, rd_addr=3; reg_we=1 in WB.
- 0x4030D213 (srai x4,x1,3) -> aluoper=0111, imm_out=3; 0x123452B7 (lui x5) -> rs1_addr=0, imm_out=0x12345000.
- 0x00108463 (beq x1,x1,+8) at pc=8 with alu_zero=1 in WB -> pc=16, reg_we=0, retire=1; same instruction with alu_zero=0 -> pc=12.
- instr_data=0x00000000 -> HALT: halted=1, instr_req stays 0, pc unchanged; assert reset -> pc=RESET_PC, halted=0, FETCH resumes.
- Reset asserted in EXEC of an addi -> no reg_we or retire; next cycle instr_req=0, then FETCH from RESET_PC.
